// File: rtl/gfp8_pkg.sv
// Shared types for the GFP8 tile dispatcher: the TILE command record,
// the per-engine state encoding and a command validity helper.
package gfp8_pkg;

  localparam int DIM_W  = 8;
  localparam int BASE_W = 9;
  localparam int ID_W   = 4;

  typedef struct packed {
    logic [DIM_W-1:0]  dim_b;
    logic [DIM_W-1:0]  dim_c;
    logic [DIM_W-1:0]  dim_v;
    logic [BASE_W-1:0] left_base;
    logic [BASE_W-1:0] right_base;
    logic [ID_W-1:0]   id;
  } cmd_t;

  localparam int CMD_W = $bits(cmd_t);

  typedef enum logic [1:0] {
    ENG_IDLE  = 2'd0,
    ENG_START = 2'd1,
    ENG_RUN   = 2'd2
  } eng_state_t;

  // A tile with any empty dimension has no work and must not reach an engine.
  function automatic logic cmd_dims_ok(input cmd_t cmd);
    return (cmd.dim_b != '0) && (cmd.dim_c != '0) && (cmd.dim_v != '0);
  endfunction

endpackage

// File: rtl/gfp8_cmd_fifo.sv
// Synchronous first-word-fall-through command FIFO. The head entry is
// visible on pop_data whenever the FIFO is non-empty; a write is never
// bypassed to the output in the same cycle.
module gfp8_cmd_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] pop_data,
  output logic             full,
  output logic             empty
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [AW:0]      count;
  logic             do_push;
  logic             do_pop;

  assign do_push  = push && !full;
  assign do_pop   = pop && !empty;
  assign full     = (count == (AW+1)'(DEPTH));
  assign empty    = (count == '0);
  assign pop_data = mem[rd_ptr];

  // Storage array; contents need no reset because count gates visibility.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= push_data;
  end

  // Read/write pointers and occupancy; power-of-two depth lets pointers wrap freely.
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/gfp8_tile_dispatcher.sv
// Accepts TILE commands into a FIFO and hands them to NUM_ENG downstream
// BCV engines in round-robin order. Each engine runs a small
// IDLE -> START -> RUN handshake and reports completion with the command tag;
// commands with an empty dimension are rejected with an error pulse instead.
module gfp8_tile_dispatcher
  import gfp8_pkg::*;
#(
  parameter int NUM_ENG    = 2,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                i_clk,
  input  logic                i_reset,
  input  logic                i_cmd_valid,
  output logic                o_cmd_ready,
  input  logic [DIM_W-1:0]    i_cmd_dim_b,
  input  logic [DIM_W-1:0]    i_cmd_dim_c,
  input  logic [DIM_W-1:0]    i_cmd_dim_v,
  input  logic [BASE_W-1:0]   i_cmd_left_base,
  input  logic [BASE_W-1:0]   i_cmd_right_base,
  input  logic [ID_W-1:0]     i_cmd_id,
  output logic [NUM_ENG-1:0]  o_eng_start,
  output logic [DIM_W-1:0]    o_eng_dim_b      [NUM_ENG],
  output logic [DIM_W-1:0]    o_eng_dim_c      [NUM_ENG],
  output logic [DIM_W-1:0]    o_eng_dim_v      [NUM_ENG],
  output logic [BASE_W-1:0]   o_eng_left_base  [NUM_ENG],
  output logic [BASE_W-1:0]   o_eng_right_base [NUM_ENG],
  input  logic [NUM_ENG-1:0]  i_eng_done,
  output logic [NUM_ENG-1:0]  o_done_valid,
  output logic [ID_W-1:0]     o_done_id        [NUM_ENG],
  output logic                o_err_valid,
  output logic [ID_W-1:0]     o_err_id,
  output logic                o_busy
);

  localparam int PTR_W = (NUM_ENG > 1) ? $clog2(NUM_ENG) : 1;

  cmd_t             push_cmd;
  cmd_t             head_cmd;
  logic [CMD_W-1:0] head_bits;
  logic             fifo_full;
  logic             fifo_empty;
  logic             push;
  logic             pop;
  logic             dispatch;
  logic             reject;

  logic             grant_found;
  logic [PTR_W-1:0] grant_idx;
  logic [PTR_W-1:0] cand;
  logic [PTR_W-1:0] rr_ptr;
  logic             any_active;

  eng_state_t       eng_state_q [NUM_ENG];
  eng_state_t       eng_state_d [NUM_ENG];
  cmd_t             eng_cmd_q   [NUM_ENG];
  logic [NUM_ENG-1:0] done_valid_q;
  logic             err_valid_q;
  logic [ID_W-1:0]  err_id_q;

  // Next engine index in the ring, wrapping after the last engine.
  function automatic logic [PTR_W-1:0] wrap_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(NUM_ENG - 1)) ? '0 : p + 1'b1;
  endfunction

  assign push_cmd = '{dim_b:      i_cmd_dim_b,
                      dim_c:      i_cmd_dim_c,
                      dim_v:      i_cmd_dim_v,
                      left_base:  i_cmd_left_base,
                      right_base: i_cmd_right_base,
                      id:         i_cmd_id};

  // Ready is held low through reset so nothing is accepted while state clears.
  assign o_cmd_ready = !fifo_full && !i_reset;
  assign push        = i_cmd_valid && o_cmd_ready;
  assign head_cmd    = cmd_t'(head_bits);

  gfp8_cmd_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (CMD_W)
  ) u_cmd_fifo (
    .clk       (i_clk),
    .reset     (i_reset),
    .push      (push),
    .push_data (push_cmd),
    .pop       (pop),
    .pop_data  (head_bits),
    .full      (fifo_full),
    .empty     (fifo_empty)
  );

  // Round-robin search for the first idle engine starting at rr_ptr.
  always_comb begin
    grant_found = 1'b0;
    grant_idx   = '0;
    cand        = rr_ptr;
    for (int i = 0; i < NUM_ENG; i++) begin
      if (!grant_found && eng_state_q[cand] == ENG_IDLE) begin
        grant_found = 1'b1;
        grant_idx   = cand;
      end
      cand = wrap_inc(cand);
    end
  end

  // A head command leaves the FIFO only when some engine could take it, even if it is then rejected.
  assign pop      = !fifo_empty && grant_found;
  assign dispatch = pop && cmd_dims_ok(head_cmd);
  assign reject   = pop && !cmd_dims_ok(head_cmd);

  // Per-engine next-state logic and start decode.
  always_comb begin
    o_eng_start = '0;
    any_active  = 1'b0;
    for (int e = 0; e < NUM_ENG; e++) begin
      eng_state_d[e] = eng_state_q[e];
      case (eng_state_q[e])
        ENG_IDLE:  if (dispatch && grant_idx == PTR_W'(e)) eng_state_d[e] = ENG_START;
        ENG_START: eng_state_d[e] = ENG_RUN;
        ENG_RUN:   if (i_eng_done[e]) eng_state_d[e] = ENG_IDLE;
        default:   eng_state_d[e] = ENG_IDLE;
      endcase
      o_eng_start[e] = (eng_state_q[e] == ENG_START);
      if (eng_state_q[e] != ENG_IDLE) any_active = 1'b1;
    end
  end

  // Engine state registers.
  always_ff @(posedge i_clk) begin
    for (int e = 0; e < NUM_ENG; e++) begin
      if (i_reset) eng_state_q[e] <= ENG_IDLE;
      else         eng_state_q[e] <= eng_state_d[e];
    end
  end

  // Latch the command into the granted engine and flag completions from RUN only.
  always_ff @(posedge i_clk) begin
    for (int e = 0; e < NUM_ENG; e++) begin
      if (i_reset) begin
        eng_cmd_q[e]    <= '0;
        done_valid_q[e] <= 1'b0;
      end else begin
        if (dispatch && grant_idx == PTR_W'(e)) eng_cmd_q[e] <= head_cmd;
        done_valid_q[e] <= (eng_state_q[e] == ENG_RUN) && i_eng_done[e];
      end
    end
  end

  // Rotate the grant pointer on real dispatches only and report rejected tags.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      rr_ptr      <= '0;
      err_valid_q <= 1'b0;
      err_id_q    <= '0;
    end else begin
      if (dispatch) rr_ptr <= wrap_inc(grant_idx);
      err_valid_q <= reject;
      if (reject) err_id_q <= head_cmd.id;
    end
  end

  // Drive per-engine field and completion-tag outputs straight from the latched command.
  always_comb begin
    for (int e = 0; e < NUM_ENG; e++) begin
      o_eng_dim_b[e]      = eng_cmd_q[e].dim_b;
      o_eng_dim_c[e]      = eng_cmd_q[e].dim_c;
      o_eng_dim_v[e]      = eng_cmd_q[e].dim_v;
      o_eng_left_base[e]  = eng_cmd_q[e].left_base;
      o_eng_right_base[e] = eng_cmd_q[e].right_base;
      o_done_id[e]        = eng_cmd_q[e].id;
    end
  end

  assign o_done_valid = done_valid_q;
  assign o_err_valid  = err_valid_q;
  assign o_err_id     = err_id_q;
  assign o_busy       = !fifo_empty || any_active;

endmodule

// File: tb/tb_gfp8_tile_dispatcher.sv
// Scoreboard bench for gfp8_tile_dispatcher: directed commands push the
// hand-derived start/done/error events (with their expected cycle) into
// queues, and a negedge monitor pops and compares whenever the DUT pulses.
module tb_gfp8_tile_dispatcher;

  localparam int NUM_ENG = 2;

  logic               i_clk;
  logic               i_reset;
  logic               i_cmd_valid;
  logic               o_cmd_ready;
  logic [7:0]         i_cmd_dim_b;
  logic [7:0]         i_cmd_dim_c;
  logic [7:0]         i_cmd_dim_v;
  logic [8:0]         i_cmd_left_base;
  logic [8:0]         i_cmd_right_base;
  logic [3:0]         i_cmd_id;
  logic [NUM_ENG-1:0] o_eng_start;
  logic [7:0]         o_eng_dim_b      [NUM_ENG];
  logic [7:0]         o_eng_dim_c      [NUM_ENG];
  logic [7:0]         o_eng_dim_v      [NUM_ENG];
  logic [8:0]         o_eng_left_base  [NUM_ENG];
  logic [8:0]         o_eng_right_base [NUM_ENG];
  logic [NUM_ENG-1:0] i_eng_done;
  logic [NUM_ENG-1:0] o_done_valid;
  logic [3:0]         o_done_id        [NUM_ENG];
  logic               o_err_valid;
  logic [3:0]         o_err_id;
  logic               o_busy;

  typedef struct {
    int          eng;
    int          cyc;
    logic [63:0] val;
  } exp_t;

  exp_t exp_start[$];
  exp_t exp_done[$];
  exp_t exp_err[$];

  int n_cmp  = 0;
  int n_fail = 0;
  int cyc    = 0;

  gfp8_tile_dispatcher #(
    .NUM_ENG    (NUM_ENG),
    .FIFO_DEPTH (4)
  ) dut (
    .i_clk            (i_clk),
    .i_reset          (i_reset),
    .i_cmd_valid      (i_cmd_valid),
    .o_cmd_ready      (o_cmd_ready),
    .i_cmd_dim_b      (i_cmd_dim_b),
    .i_cmd_dim_c      (i_cmd_dim_c),
    .i_cmd_dim_v      (i_cmd_dim_v),
    .i_cmd_left_base  (i_cmd_left_base),
    .i_cmd_right_base (i_cmd_right_base),
    .i_cmd_id         (i_cmd_id),
    .o_eng_start      (o_eng_start),
    .o_eng_dim_b      (o_eng_dim_b),
    .o_eng_dim_c      (o_eng_dim_c),
    .o_eng_dim_v      (o_eng_dim_v),
    .o_eng_left_base  (o_eng_left_base),
    .o_eng_right_base (o_eng_right_base),
    .i_eng_done       (i_eng_done),
    .o_done_valid     (o_done_valid),
    .o_done_id        (o_done_id),
    .o_err_valid      (o_err_valid),
    .o_err_id         (o_err_id),
    .o_busy           (o_busy)
  );

  // Free-running clock and a cycle counter that advances on every rising edge.
  initial i_clk = 1'b0;
  always #5 i_clk = ~i_clk;
  always @(posedge i_clk) cyc <= cyc + 1;

  // Hard stop if anything runs away.
  always @(posedge i_clk) begin
    if (cyc > 4000) begin
      $display("[TB] FAIL watchdog: cycle=%0d limit=4000", cyc);
      $fatal(1, "[TB] watchdog expired");
    end
  end

  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] req);
    n_cmp++;
    if (act !== req) begin
      n_fail++;
      $display("[TB] FAIL %s: actual=0x%0h required=0x%0h at cycle %0d", name, act, req, cyc);
    end
  endtask

  task automatic reportUnexpected(input string name, input int eng);
    n_cmp++;
    n_fail++;
    $display("[TB] FAIL %s: actual=pulse on engine %0d required=no pulse at cycle %0d", name, eng, cyc);
  endtask

  // Scoreboard monitor: every start/done/error pulse must match the oldest expectation.
  always @(negedge i_clk) begin
    exp_t ev;
    for (int e = 0; e < NUM_ENG; e++) begin
      if (o_eng_start[e]) begin
        if (exp_start.size() == 0) reportUnexpected("start_unexpected", e);
        else begin
          ev = exp_start.pop_front();
          checkOutput("start_engine", 64'(e), 64'(ev.eng));
          checkOutput("start_cycle", 64'(cyc), 64'(ev.cyc));
          checkOutput("start_fields", {22'd0, o_eng_dim_b[e], o_eng_dim_c[e], o_eng_dim_v[e],
                                       o_eng_left_base[e], o_eng_right_base[e]}, ev.val);
        end
      end
    end
    for (int e = 0; e < NUM_ENG; e++) begin
      if (o_done_valid[e]) begin
        if (exp_done.size() == 0) reportUnexpected("done_unexpected", e);
        else begin
          ev = exp_done.pop_front();
          checkOutput("done_engine", 64'(e), 64'(ev.eng));
          checkOutput("done_cycle", 64'(cyc), 64'(ev.cyc));
          checkOutput("done_id", {60'd0, o_done_id[e]}, ev.val);
        end
      end
    end
    if (o_err_valid) begin
      if (exp_err.size() == 0) reportUnexpected("err_unexpected", 0);
      else begin
        ev = exp_err.pop_front();
        checkOutput("err_cycle", 64'(cyc), 64'(ev.cyc));
        checkOutput("err_id", {60'd0, o_err_id}, ev.val);
      end
    end
  end

  task automatic expectStart(input int eng, input int c, input logic [7:0] b, input logic [7:0] cc,
                             input logic [7:0] v, input logic [8:0] l, input logic [8:0] r);
    exp_t ev;
    ev.eng = eng;
    ev.cyc = c;
    ev.val = {22'd0, b, cc, v, l, r};
    exp_start.push_back(ev);
  endtask

  task automatic expectDone(input int eng, input int c, input logic [3:0] id);
    exp_t ev;
    ev.eng = eng;
    ev.cyc = c;
    ev.val = {60'd0, id};
    exp_done.push_back(ev);
  endtask

  task automatic expectErr(input int c, input logic [3:0] id);
    exp_t ev;
    ev.eng = 0;
    ev.cyc = c;
    ev.val = {60'd0, id};
    exp_err.push_back(ev);
  endtask

  // Offer one command starting just after a rising edge; acc is the cycle it was accepted in.
  task automatic applyStimulus(input logic [7:0] b, input logic [7:0] c, input logic [7:0] v,
                               input logic [8:0] l, input logic [8:0] r, input logic [3:0] id,
                               output int acc);
    int tries;
    tries            = 0;
    i_cmd_valid      = 1'b1;
    i_cmd_dim_b      = b;
    i_cmd_dim_c      = c;
    i_cmd_dim_v      = v;
    i_cmd_left_base  = l;
    i_cmd_right_base = r;
    i_cmd_id         = id;
    @(negedge i_clk);
    while (!o_cmd_ready && tries < 50) begin
      @(negedge i_clk);
      tries++;
    end
    checkOutput("cmd_accept", {63'd0, o_cmd_ready}, 64'd1);
    acc = o_cmd_ready ? cyc : -1;
    @(posedge i_clk);
    #1;
    i_cmd_valid = 1'b0;
  endtask

  // Numbered command used by the back-to-back sequence.
  task automatic applyIdx(input int i, output int acc);
    applyStimulus(8'(16 + i), 8'(32 + i), 8'(48 + i), 9'(256 + i), 9'(128 + i), 4'(i), acc);
  endtask

  task automatic expectStartIdx(input int eng, input int c, input int i);
    expectStart(eng, c, 8'(16 + i), 8'(32 + i), 8'(48 + i), 9'(256 + i), 9'(128 + i));
  endtask

  // Pulse i_eng_done for one cycle; d is the cycle the pulse was driven in.
  task automatic pulseDone(input logic [NUM_ENG-1:0] mask, output int d);
    d          = cyc;
    i_eng_done = mask;
    @(posedge i_clk);
    #1;
    i_eng_done = '0;
  endtask

  task automatic waitCycle(input int n);
    while (cyc < n) begin
      @(posedge i_clk);
      #1;
    end
  endtask

  task automatic toNextCycle();
    @(posedge i_clk);
    #1;
  endtask

  int acc;
  int acc2;
  int d;
  int accs [1:6];

  initial begin
    i_reset          = 1'b1;
    i_cmd_valid      = 1'b0;
    i_cmd_dim_b      = '0;
    i_cmd_dim_c      = '0;
    i_cmd_dim_v      = '0;
    i_cmd_left_base  = '0;
    i_cmd_right_base = '0;
    i_cmd_id         = '0;
    i_eng_done       = '0;

    // Reset state
    repeat (3) @(posedge i_clk);
    #1;
    @(negedge i_clk);
    checkOutput("reset_ready", {63'd0, o_cmd_ready}, 64'd0);
    checkOutput("reset_busy", {63'd0, o_busy}, 64'd0);
    checkOutput("reset_start", {62'd0, o_eng_start}, 64'd0);
    checkOutput("reset_done_valid", {62'd0, o_done_valid}, 64'd0);
    checkOutput("reset_err_valid", {63'd0, o_err_valid}, 64'd0);
    checkOutput("reset_dim_b0", {56'd0, o_eng_dim_b[0]}, 64'd0);
    toNextCycle();
    i_reset = 1'b0;
    @(negedge i_clk);
    checkOutput("ready_after_reset", {63'd0, o_cmd_ready}, 64'd1);
    toNextCycle();

    // Single command, engine reports done 50 cycles later
    $display("[TB] single command");
    applyStimulus(8'd2, 8'd3, 8'd4, 9'h011, 9'h022, 4'd5, acc);
    expectStart(0, acc + 2, 8'd2, 8'd3, 8'd4, 9'h011, 9'h022);
    waitCycle(acc + 4);
    @(negedge i_clk);
    checkOutput("busy_running", {63'd0, o_busy}, 64'd1);
    checkOutput("fields_held_v0", {56'd0, o_eng_dim_v[0]}, 64'd4);
    toNextCycle();
    waitCycle(acc + 52);
    pulseDone(2'b01, d);
    expectDone(0, d + 1, 4'd5);
    waitCycle(d + 2);
    @(negedge i_clk);
    checkOutput("busy_after_done", {63'd0, o_busy}, 64'd0);
    toNextCycle();

    // Spurious done on an idle engine
    $display("[TB] spurious done");
    pulseDone(2'b10, d);
    @(negedge i_clk);
    checkOutput("spurious_done_valid", {62'd0, o_done_valid}, 64'd0);
    checkOutput("spurious_busy", {63'd0, o_busy}, 64'd0);
    toNextCycle();

    // Zero dimension is rejected; the next command still goes to engine 1
    $display("[TB] rejected command");
    applyStimulus(8'd1, 8'd1, 8'd0, 9'h003, 9'h004, 4'd9, acc);
    expectErr(acc + 2, 4'd9);
    applyStimulus(8'd1, 8'd1, 8'd1, 9'h001, 9'h002, 4'd3, acc2);
    expectStart(1, acc2 + 2, 8'd1, 8'd1, 8'd1, 9'h001, 9'h002);
    checkOutput("reject_b2b_accept", 64'(acc2), 64'(acc + 1));
    waitCycle(acc2 + 5);
    pulseDone(2'b10, d);
    expectDone(1, d + 1, 4'd3);
    waitCycle(d + 2);

    // Back-to-back commands with engines held busy until the FIFO fills
    $display("[TB] back-to-back fill");
    for (int i = 1; i <= 6; i++) begin
      applyIdx(i, accs[i]);
      if (i == 1) expectStartIdx(0, accs[1] + 2, 1);
      if (i == 2) expectStartIdx(1, accs[2] + 2, 2);
    end
    for (int i = 2; i <= 6; i++) checkOutput("b2b_accept_cycle", 64'(accs[i]), 64'(accs[1] + i - 1));
    @(negedge i_clk);
    checkOutput("ready_when_full", {63'd0, o_cmd_ready}, 64'd0);
    checkOutput("busy_when_full", {63'd0, o_busy}, 64'd1);
    toNextCycle();

    // Both engines finish together, then pick up the next two queued commands
    $display("[TB] simultaneous done");
    waitCycle(accs[1] + 10);
    pulseDone(2'b11, d);
    expectDone(0, d + 1, 4'd1);
    expectDone(1, d + 1, 4'd2);
    expectStartIdx(0, d + 2, 3);
    expectStartIdx(1, d + 3, 4);

    // Reset with both engines running and three commands queued
    $display("[TB] reset mid-operation");
    waitCycle(d + 5);
    applyIdx(7, acc);
    i_reset    = 1'b1;
    i_eng_done = 2'b11;
    toNextCycle();
    i_eng_done = '0;
    @(negedge i_clk);
    checkOutput("midreset_ready", {63'd0, o_cmd_ready}, 64'd0);
    checkOutput("midreset_busy", {63'd0, o_busy}, 64'd0);
    checkOutput("midreset_start", {62'd0, o_eng_start}, 64'd0);
    checkOutput("midreset_done_valid", {62'd0, o_done_valid}, 64'd0);
    checkOutput("midreset_err_id", {60'd0, o_err_id}, 64'd0);
    checkOutput("midreset_left_base1", {55'd0, o_eng_left_base[1]}, 64'd0);
    checkOutput("midreset_done_id0", {60'd0, o_done_id[0]}, 64'd0);
    toNextCycle();
    i_reset = 1'b0;
    @(negedge i_clk);
    checkOutput("ready_after_midreset", {63'd0, o_cmd_ready}, 64'd1);
    checkOutput("busy_after_midreset", {63'd0, o_busy}, 64'd0);
    toNextCycle();
    applyStimulus(8'd7, 8'd6, 8'd5, 9'h1AA, 9'h155, 4'hA, acc);
    expectStart(0, acc + 2, 8'd7, 8'd6, 8'd5, 9'h1AA, 9'h155);
    waitCycle(acc + 4);
    pulseDone(2'b01, d);
    expectDone(0, d + 1, 4'hA);
    waitCycle(d + 3);

    @(negedge i_clk);
    checkOutput("final_busy", {63'd0, o_busy}, 64'd0);
    checkOutput("pending_starts", 64'(exp_start.size()), 64'd0);
    checkOutput("pending_dones", 64'(exp_done.size()), 64'd0);
    checkOutput("pending_errs", 64'(exp_err.size()), 64'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
